pipe_mem_load: RTL and testbench

- MEM pipeline stage, between EX and WB.
- Registers EX results and waits for the data-bus response on loads.
- Performs load byte/halfword extraction with sign/zero extension and forwards the result, register write control and CP0/exception fields to WB.
- Uses the valid/allowin handshake; discards in-flight loads on WB flush.

---
 rtl/pipe_mem_load_pkg.sv | 40 ++++
 rtl/pipe_mem_load_if.sv | 36 +++
 rtl/pipe_mem_load_align.sv | 28 ++
 rtl/pipe_mem_load.sv | 150 +++++++++++++++
 tb/tb_pipe_mem_load.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_mem_load_pkg.sv
// Shared types for the MEM stage: load encodings, FSM states and the EX->MEM payload.
package pipe_mem_load_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned LT_W  = 3;

  typedef enum logic [LT_W-1:0] {
    LT_LW  = 3'd0,
    LT_LB  = 3'd1,
    LT_LBU = 3'd2,
    LT_LH  = 3'd3,
    LT_LHU = 3'd4
  } load_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HAVE  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic [XLEN-1:0]  alu_result;
    logic [REG_W-1:0] rdc;
    logic             rf_we;
    logic             load;
    load_type_e       load_type;
    logic             cp0_rd_mux_sel;
    logic             cp0_we;
    logic             ex_mem;
    logic             eret_flush;
    logic             branch_delay;
    logic [REG_W-1:0] cp0_rdc;
    logic [XLEN-1:0]  cp0_data;
    logic [XLEN-1:0]  pc;
    logic [REG_W-1:0] ex_code;
  } mem_payload_t;

endpackage

// File: rtl/pipe_mem_load_if.sv
// EX->MEM valid/allowin handshake and instruction payload.
interface pipe_mem_load_if;
  import pipe_mem_load_pkg::*;

  logic             ex_mem_validto;
  logic             mem_allowin;
  logic [XLEN-1:0]  alu_result_in;
  logic [REG_W-1:0] rdc_ex_in;
  logic             rf_we_in;
  logic             load_in;
  logic [LT_W-1:0]  load_type_in;
  logic             cp0_rd_mux_sel_in;
  logic             cp0_we_in;
  logic             ex_mem_in;
  logic             eret_flush_in;
  logic             branch_delay_in;
  logic [REG_W-1:0] cp0_rdc_in;
  logic [XLEN-1:0]  cp0_data_in;
  logic [XLEN-1:0]  pc_in;
  logic [REG_W-1:0] ex_code_in;

  modport master (
    output ex_mem_validto, alu_result_in, rdc_ex_in, rf_we_in, load_in, load_type_in,
           cp0_rd_mux_sel_in, cp0_we_in, ex_mem_in, eret_flush_in, branch_delay_in,
           cp0_rdc_in, cp0_data_in, pc_in, ex_code_in,
    input  mem_allowin
  );

  modport slave (
    input  ex_mem_validto, alu_result_in, rdc_ex_in, rf_we_in, load_in, load_type_in,
           cp0_rd_mux_sel_in, cp0_we_in, ex_mem_in, eret_flush_in, branch_delay_in,
           cp0_rdc_in, cp0_data_in, pc_in, ex_code_in,
    output mem_allowin
  );

endinterface

// File: rtl/pipe_mem_load_align.sv
// Load data alignment: byte/halfword select from the bus word with sign or zero extension.
module load_align
  import pipe_mem_load_pkg::*;
(
  input  load_type_e      load_type_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = rdata_i;
    case (load_type_i)
      LT_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  data_o = {24'h0, byte_sel};
      LT_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/pipe_mem_load.sv
// MEM pipeline stage: registers EX results, waits for load data, aligns it and hands off to WB.
module pipe_mem_load
  import pipe_mem_load_pkg::*;
#(
  parameter int unsigned WAIT_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_mem_load_if.slave        ex_if,
  input  logic                  wb_allowin,
  output logic                  mem_wb_validto,
  input  logic                  flush,
  input  logic [XLEN-1:0]       data_rdata,
  input  logic                  data_rvalid,
  output logic [XLEN-1:0]       wb_result_in_o,
  output logic [REG_W-1:0]      rdc_mem,
  output logic                  rf_we_o,
  output logic                  cp0_rd_mux_sel_o,
  output logic                  cp0_we_o,
  output logic                  ex_mem_o,
  output logic                  eret_flush_o,
  output logic                  branch_delay_o,
  output logic [REG_W-1:0]      cp0_rdc_o,
  output logic [XLEN-1:0]       cp0_data_o,
  output logic [XLEN-1:0]       pc_o,
  output logic [REG_W-1:0]      ex_code_o,
  output logic [XLEN-1:0]       bypass_mem,
  output logic                  mem_rdc_valid,
  output logic                  mem_load_busy,
  output logic [WAIT_CNT_W-1:0] stall_cnt
);

  mem_state_e           state_q;
  logic                 mem_valid_q;
  mem_payload_t         pipe_q;
  mem_payload_t         pipe_d;
  logic [XLEN-1:0]      hold_q;
  logic [WAIT_CNT_W-1:0] stall_cnt_q;

  logic            ld_wait;
  logic            mem_ready_go;
  logic            accept;
  logic            load_start;
  logic            handoff;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] result;

  // An excepting load never issued a bus request, so it must not wait for one.
  assign ld_wait      = pipe_q.load & ~pipe_q.ex_mem;
  assign mem_ready_go = ~ld_wait | (state_q == ST_HAVE);

  assign ex_if.mem_allowin = (state_q != ST_DRAIN) & (~mem_valid_q | (mem_ready_go & wb_allowin));
  assign accept            = ex_if.ex_mem_validto & ex_if.mem_allowin;
  assign load_start        = accept & ex_if.load_in & ~ex_if.ex_mem_in;
  assign mem_wb_validto    = mem_valid_q & mem_ready_go & ~flush;
  assign handoff           = mem_wb_validto & wb_allowin;

  always_comb begin
    pipe_d                = '0;
    pipe_d.alu_result     = ex_if.alu_result_in;
    pipe_d.rdc            = ex_if.rdc_ex_in;
    pipe_d.rf_we          = ex_if.rf_we_in;
    pipe_d.load           = ex_if.load_in;
    pipe_d.load_type      = load_type_e'(ex_if.load_type_in);
    pipe_d.cp0_rd_mux_sel = ex_if.cp0_rd_mux_sel_in;
    pipe_d.cp0_we         = ex_if.cp0_we_in;
    pipe_d.ex_mem         = ex_if.ex_mem_in;
    pipe_d.eret_flush     = ex_if.eret_flush_in;
    pipe_d.branch_delay   = ex_if.branch_delay_in;
    pipe_d.cp0_rdc        = ex_if.cp0_rdc_in;
    pipe_d.cp0_data       = ex_if.cp0_data_in;
    pipe_d.pc             = ex_if.pc_in;
    pipe_d.ex_code        = ex_if.ex_code_in;
  end

  // Stage state, load FSM and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_valid_q <= 1'b0;
      pipe_q      <= '0;
      hold_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (ex_if.mem_allowin) begin
        mem_valid_q <= ex_if.ex_mem_validto & ~flush;
      end else if (flush) begin
        mem_valid_q <= 1'b0;
      end

      if (accept) begin
        pipe_q <= pipe_d;
      end

      if ((state_q == ST_WAIT || state_q == ST_DRAIN) && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + WAIT_CNT_W'(1);
      end

      // A load accepted under flush still has a response in flight, so it drains.
      case (state_q)
        ST_IDLE: begin
          if (load_start) state_q <= flush ? ST_DRAIN : ST_WAIT;
        end
        ST_WAIT: begin
          if (data_rvalid) begin
            state_q <= flush ? ST_IDLE : ST_HAVE;
            hold_q  <= data_rdata;
          end else if (flush) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_HAVE: begin
          if (load_start) state_q <= flush ? ST_DRAIN : ST_WAIT;
          else if (flush || handoff) state_q <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (data_rvalid) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  load_align u_load_align (
    .load_type_i (pipe_q.load_type),
    .addr_lo_i   (pipe_q.alu_result[1:0]),
    .rdata_i     (hold_q),
    .data_o      (load_data)
  );

  assign result = ld_wait ? load_data : pipe_q.alu_result;

  assign wb_result_in_o   = result;
  assign bypass_mem       = result;
  assign rdc_mem          = pipe_q.rdc;
  assign rf_we_o          = pipe_q.rf_we & ~pipe_q.ex_mem;
  assign mem_rdc_valid    = mem_valid_q & rf_we_o & mem_ready_go;
  assign cp0_rd_mux_sel_o = pipe_q.cp0_rd_mux_sel;
  assign cp0_we_o         = pipe_q.cp0_we;
  assign ex_mem_o         = pipe_q.ex_mem;
  assign eret_flush_o     = pipe_q.eret_flush;
  assign branch_delay_o   = pipe_q.branch_delay;
  assign cp0_rdc_o        = pipe_q.cp0_rdc;
  assign cp0_data_o       = pipe_q.cp0_data;
  assign pc_o             = pipe_q.pc;
  assign ex_code_o        = pipe_q.ex_code;
  assign mem_load_busy    = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  assign stall_cnt        = stall_cnt_q;

endmodule

// File: tb/tb_pipe_mem_load.sv
// Scoreboard bench for pipe_mem_load: expected WB payloads queued on EX accept, checked on WB handoff.
module tb_pipe_mem_load;
  import pipe_mem_load_pkg::*;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic wb_allowin, flush, data_rvalid;
  logic [31:0] data_rdata;
  logic mem_wb_validto, rf_we_o, mem_rdc_valid, mem_load_busy;
  logic cp0_rd_mux_sel_o, cp0_we_o, ex_mem_o, eret_flush_o, branch_delay_o;
  logic [4:0] rdc_mem, cp0_rdc_o, ex_code_o;
  logic [31:0] wb_result_in_o, cp0_data_o, pc_o, bypass_mem;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_mem_load_if ex_if ();

  pipe_mem_load #(.WAIT_CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ex_if(ex_if), .wb_allowin(wb_allowin), .mem_wb_validto(mem_wb_validto),
    .flush(flush), .data_rdata(data_rdata), .data_rvalid(data_rvalid),
    .wb_result_in_o(wb_result_in_o), .rdc_mem(rdc_mem), .rf_we_o(rf_we_o),
    .cp0_rd_mux_sel_o(cp0_rd_mux_sel_o), .cp0_we_o(cp0_we_o), .ex_mem_o(ex_mem_o),
    .eret_flush_o(eret_flush_o), .branch_delay_o(branch_delay_o), .cp0_rdc_o(cp0_rdc_o),
    .cp0_data_o(cp0_data_o), .pc_o(pc_o), .ex_code_o(ex_code_o), .bypass_mem(bypass_mem),
    .mem_rdc_valid(mem_rdc_valid), .mem_load_busy(mem_load_busy), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rdc;
    logic        rf_we;
    logic [31:0] pc;
    logic [4:0]  ex_code;
    logic [31:0] cp0_data;
  } exp_t;

  exp_t        sb[$];
  exp_t        pend;
  int          n_tests;
  int          n_fail;
  int unsigned stall_exp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [31:0] addr,
                                             input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (32'(addr[1:0]) * 8);
    case (lt)
      3'd1:    return {{24{sh[7]}}, sh[7:0]};
      3'd2:    return {24'h0, sh[7:0]};
      3'd3:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return {16'h0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b);
    return (a + b > CNT_MAX) ? CNT_MAX : a + b;
  endfunction

  task automatic clear_ex();
    ex_if.ex_mem_validto    = 1'b0;
    ex_if.alu_result_in     = '0;
    ex_if.rdc_ex_in         = '0;
    ex_if.rf_we_in          = 1'b0;
    ex_if.load_in           = 1'b0;
    ex_if.load_type_in      = '0;
    ex_if.cp0_rd_mux_sel_in = 1'b0;
    ex_if.cp0_we_in         = 1'b0;
    ex_if.ex_mem_in         = 1'b0;
    ex_if.eret_flush_in     = 1'b0;
    ex_if.branch_delay_in   = 1'b0;
    ex_if.cp0_rdc_in        = '0;
    ex_if.cp0_data_in       = '0;
    ex_if.pc_in             = '0;
    ex_if.ex_code_in        = '0;
  endtask

  task automatic offer(input logic [31:0] alu, input logic [4:0] rdc, input logic rf_we,
                       input logic ld, input logic [2:0] lt, input logic exc,
                       input logic [31:0] pc, input logic [4:0] code, input logic [31:0] rd_plan);
    ex_if.ex_mem_validto = 1'b1;
    ex_if.alu_result_in  = alu;
    ex_if.rdc_ex_in      = rdc;
    ex_if.rf_we_in       = rf_we;
    ex_if.load_in        = ld;
    ex_if.load_type_in   = lt;
    ex_if.ex_mem_in      = exc;
    ex_if.pc_in          = pc;
    ex_if.ex_code_in     = code;
    ex_if.cp0_data_in    = ~pc;
    ex_if.cp0_rdc_in     = rdc ^ 5'h1F;
    pend.result   = (ld && !exc) ? model_load(lt, alu, rd_plan) : alu;
    pend.rdc      = rdc;
    pend.rf_we    = rf_we & ~exc;
    pend.pc       = pc;
    pend.ex_code  = code;
    pend.cp0_data = ~pc;
  endtask

  // One cycle: settle, score any WB handoff, record any EX accept, advance to next negedge.
  task automatic tick();
    exp_t e;
    #1;
    if (mem_wb_validto && wb_allowin) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_wb", 32'(mem_wb_validto), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("wb_result", wb_result_in_o, e.result);
        check_eq("wb_rdc", 32'(rdc_mem), 32'(e.rdc));
        check_eq("wb_rf_we", 32'(rf_we_o), 32'(e.rf_we));
        check_eq("wb_pc", pc_o, e.pc);
        check_eq("wb_ex_code", 32'(ex_code_o), 32'(e.ex_code));
        check_eq("wb_cp0_data", cp0_data_o, e.cp0_data);
      end
    end
    if (flush || rst) sb.delete();
    if (ex_if.ex_mem_validto && ex_if.mem_allowin && !flush && !rst) sb.push_back(pend);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_load(input logic [31:0] alu, input logic [2:0] lt, input logic [31:0] rd,
                          input int dly);
    int busy_n;
    busy_n = 0;
    offer(alu, 5'd8, 1'b1, 1'b1, lt, 1'b0, 32'h0040_1000 + alu, 5'd0, rd);
    tick();
    ex_if.ex_mem_validto = 1'b0;
    for (int i = 1; i <= dly; i++) begin
      data_rvalid = (i == dly);
      data_rdata  = (i == dly) ? rd : 32'h5A5A_0000 + 32'(i);
      #1;
      if (mem_load_busy) busy_n++;
      if (i == 1) begin
        check_eq("ld_wait_fwd", 32'(mem_rdc_valid), 32'd0);
        check_eq("ld_wait_offer", 32'(mem_wb_validto), 32'd0);
      end
      tick();
    end
    data_rvalid = 1'b0;
    stall_exp = sat_add(stall_exp, 32'(dly));
    #1;
    check_eq("ld_busy_cycles", 32'(busy_n), 32'(dly));
    check_eq("ld_stall_cnt", 32'(stall_cnt), stall_exp);
    check_eq("ld_offer", 32'(mem_wb_validto), 32'd1);
    check_eq("ld_fwd_valid", 32'(mem_rdc_valid), 32'd1);
    check_eq("ld_bypass", bypass_mem, model_load(lt, alu, rd));
    tick();
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    stall_exp   = 0;
    rst         = 1'b1;
    wb_allowin  = 1'b1;
    flush       = 1'b0;
    data_rvalid = 1'b0;
    data_rdata  = '0;
    clear_ex();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_allowin", 32'(ex_if.mem_allowin), 32'd1);
    check_eq("rst_offer", 32'(mem_wb_validto), 32'd0);
    check_eq("rst_stall", 32'(stall_cnt), 32'd0);
    check_eq("rst_busy", 32'(mem_load_busy), 32'd0);
    check_eq("rst_result", wb_result_in_o, 32'd0);
    check_eq("rst_rf_we", 32'(rf_we_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Plain ALU op: one-cycle latency to WB.
    offer(32'h1234_5678, 5'd3, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0040_0000, 5'd0, 32'h0);
    tick();
    ex_if.ex_mem_validto = 1'b0;
    #1;
    check_eq("alu_offer", 32'(mem_wb_validto), 32'd1);
    check_eq("alu_result", wb_result_in_o, 32'h1234_5678);
    check_eq("alu_fwd_valid", 32'(mem_rdc_valid), 32'd1);
    check_eq("alu_bypass", bypass_mem, 32'h1234_5678);
    tick();

    // Back-to-back ALU ops are accepted every cycle.
    for (int i = 0; i < 3; i++) begin
      offer(32'hA000_0000 + 32'(i), 5'(4 + i), 1'b1, 1'b0, 3'd0, 1'b0, 32'h0040_0100 + 32'(4 * i),
            5'd0, 32'h0);
      #1;
      check_eq("b2b_allowin", 32'(ex_if.mem_allowin), 32'd1);
      tick();
    end
    ex_if.ex_mem_validto = 1'b0;
    tick();

    // Load extraction patterns.
    run_load(32'h1000_0003, 3'd1, 32'h80FF_0102, 3);
    run_load(32'h1000_0002, 3'd4, 32'hBEEF_0000, 1);
    run_load(32'h1000_0002, 3'd3, 32'hBEEF_0000, 2);
    run_load(32'h1000_0001, 3'd2, 32'h1234_5678, 1);
    run_load(32'h1000_0000, 3'd1, 32'h0000_007F, 1);
    run_load(32'h1000_0000, 3'd3, 32'h0000_8001, 2);
    run_load(32'h1000_0004, 3'd0, 32'hCAFE_F00D, 1);

    // Flush while waiting: the stale response drains and never reaches WB.
    offer(32'h0000_0100, 5'd9, 1'b1, 1'b1, 3'd0, 1'b0, 32'h0040_2000, 5'd0, 32'hDEAD_BEEF);
    tick();
    ex_if.ex_mem_validto = 1'b0;
    flush = 1'b1;
    #1;
    check_eq("flush_no_offer", 32'(mem_wb_validto), 32'd0);
    tick();
    flush = 1'b0;
    offer(32'h0000_0AA0, 5'd10, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0040_2004, 5'd0, 32'h0);
    #1;
    check_eq("drain_allowin", 32'(ex_if.mem_allowin), 32'd0);
    check_eq("drain_busy", 32'(mem_load_busy), 32'd1);
    tick();
    data_rvalid = 1'b1;
    data_rdata  = 32'hDEAD_BEEF;
    #1;
    check_eq("drain_allowin_rv", 32'(ex_if.mem_allowin), 32'd0);
    check_eq("drain_no_offer", 32'(mem_wb_validto), 32'd0);
    tick();
    data_rvalid = 1'b0;
    #1;
    check_eq("post_drain_allowin", 32'(ex_if.mem_allowin), 32'd1);
    check_eq("post_drain_no_offer", 32'(mem_wb_validto), 32'd0);
    tick();
    ex_if.ex_mem_validto = 1'b0;
    stall_exp = sat_add(stall_exp, 3);
    #1;
    check_eq("post_drain_result", wb_result_in_o, 32'h0000_0AA0);
    check_eq("drain_stall_cnt", 32'(stall_cnt), stall_exp);
    tick();

    // Loaded data held while WB stalls; back-to-back load accepted on handoff.
    wb_allowin = 1'b0;
    offer(32'h2000_0001, 5'd11, 1'b1, 1'b1, 3'd2, 1'b0, 32'h0040_3000, 5'd0, 32'h0000_AB00);
    tick();
    ex_if.ex_mem_validto = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'h0000_AB00;
    tick();
    data_rvalid = 1'b0;
    offer(32'h0000_0200, 5'd12, 1'b1, 1'b1, 3'd0, 1'b0, 32'h0040_3004, 5'd0, 32'h1122_3344);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("have_hold_result", wb_result_in_o, 32'h0000_00AB);
      check_eq("have_hold_allowin", 32'(ex_if.mem_allowin), 32'd0);
      check_eq("have_hold_offer", 32'(mem_wb_validto), 32'd1);
      tick();
    end
    wb_allowin = 1'b1;
    #1;
    check_eq("have_release_allowin", 32'(ex_if.mem_allowin), 32'd1);
    tick();
    ex_if.ex_mem_validto = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'h1122_3344;
    #1;
    check_eq("b2b_load_busy", 32'(mem_load_busy), 32'd1);
    tick();
    data_rvalid = 1'b0;
    stall_exp = sat_add(stall_exp, 2);
    #1;
    check_eq("b2b_load_offer", 32'(mem_wb_validto), 32'd1);
    check_eq("b2b_stall_cnt", 32'(stall_cnt), stall_exp);
    tick();

    // Excepting instruction never writes the register file.
    offer(32'h0BAD_0000, 5'd7, 1'b1, 1'b0, 3'd0, 1'b1, 32'h0040_4000, 5'd12, 32'h0);
    tick();
    ex_if.ex_mem_validto = 1'b0;
    #1;
    check_eq("exc_rf_we", 32'(rf_we_o), 32'd0);
    check_eq("exc_fwd_valid", 32'(mem_rdc_valid), 32'd0);
    check_eq("exc_ex_mem", 32'(ex_mem_o), 32'd1);
    check_eq("exc_code", 32'(ex_code_o), 32'd12);
    check_eq("exc_pc", pc_o, 32'h0040_4000);
    check_eq("exc_offer", 32'(mem_wb_validto), 32'd1);
    tick();

    // Long wait saturates the stall counter; reset mid-load returns to idle.
    offer(32'h0000_0300, 5'd13, 1'b1, 1'b1, 3'd0, 1'b0, 32'h0040_5000, 5'd0, 32'h0);
    tick();
    ex_if.ex_mem_validto = 1'b0;
    repeat (260) tick();
    stall_exp = sat_add(stall_exp, 260);
    #1;
    check_eq("sat_stall_cnt", 32'(stall_cnt), stall_exp);
    check_eq("sat_busy", 32'(mem_load_busy), 32'd1);
    check_eq("sat_fwd_valid", 32'(mem_rdc_valid), 32'd0);
    check_eq("sat_allowin", 32'(ex_if.mem_allowin), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall_exp = 0;
    #1;
    check_eq("midrst_stall", 32'(stall_cnt), stall_exp);
    check_eq("midrst_busy", 32'(mem_load_busy), 32'd0);
    check_eq("midrst_allowin", 32'(ex_if.mem_allowin), 32'd1);
    check_eq("midrst_offer", 32'(mem_wb_validto), 32'd0);
    offer(32'h7777_0000, 5'd14, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0040_6000, 5'd0, 32'h0);
    tick();
    ex_if.ex_mem_validto = 1'b0;
    tick();
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
